rail_gate_sequencer: RTL and testbench



---
 rtl/rail_gate_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rail_gate_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rail_gate_sequencer.sv
// Level-crossing gate sequencer: conditions the track sensors and limit switches,
// runs the warn/lower/closed/hold/raise cycle with motion timeouts, drives lamps and motors.
module rail_gate_sequencer #(
  parameter int unsigned TICK_CYCLES        = 50_000_000,
  parameter int unsigned DEB_CYCLES         = 1_000_000,
  parameter int unsigned WARN_TICKS         = 10,
  parameter int unsigned MOVE_TIMEOUT_TICKS = 20,
  parameter int unsigned CLEAR_HOLD_TICKS   = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       approach_in,
  input  logic       depart_in,
  input  logic       gate_down_lim,
  input  logic       gate_up_lim,
  output logic       motor_down,
  output logic       motor_up,
  output logic       LED1,
  output logic       LED2,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int unsigned PW = $clog2(TICK_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TMR_MAX =
    (WARN_TICKS > MOVE_TIMEOUT_TICKS) ?
      ((WARN_TICKS > CLEAR_HOLD_TICKS) ? WARN_TICKS : CLEAR_HOLD_TICKS) :
      ((MOVE_TIMEOUT_TICKS > CLEAR_HOLD_TICKS) ? MOVE_TIMEOUT_TICKS : CLEAR_HOLD_TICKS);
  localparam int unsigned TW = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WARN     = 3'd1,
    LOWERING = 3'd2,
    CLOSED   = 3'd3,
    HOLD     = 3'd4,
    RAISING  = 3'd5,
    FAULT    = 3'd6
  } state_t;

  // Synchronizers sample continuously, so the limits are valid the moment reset lifts.
  logic [3:0] sync1, sync2;
  always_ff @(posedge clk_100MHz) begin
    sync1 <= {gate_up_lim, gate_down_lim, depart_in, approach_in};
    sync2 <= sync1;
  end

  logic up_lim, down_lim;
  assign down_lim = sync2[2];
  assign up_lim   = sync2[3];

  // Debounce approach (bit 0) and depart (bit 1); edge detect on the debounced levels.
  logic [1:0]    deb, deb_prev;
  logic [DW-1:0] deb_cnt [2];
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      deb        <= '0;
      deb_prev   <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic approach_lvl, approach_rise_c, depart_rise_c;
  assign approach_lvl    = deb[0];
  assign approach_rise_c = deb[0] & ~deb_prev[0];
  assign depart_rise_c   = deb[1] & ~deb_prev[1];

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [PW-1:0] presc;
  logic          tick_c, timer_last_c, lamp_active_c, blink;

  assign tick_c        = (presc == PW'(TICK_CYCLES - 1));
  assign timer_last_c  = (timer <= TW'(1));
  assign lamp_active_c = state inside {WARN, LOWERING, CLOSED, HOLD, RAISING};

  // Next-state and timer reload/decrement; the both-limits check overrides everything.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (approach_rise_c) begin
          state_nxt = WARN;
          timer_nxt = TW'(WARN_TICKS);
        end else if (!up_lim) begin
          state_nxt = RAISING;
          timer_nxt = TW'(MOVE_TIMEOUT_TICKS);
        end
      end
      WARN: begin
        if (tick_c) begin
          if (timer_last_c) begin
            state_nxt = LOWERING;
            timer_nxt = TW'(MOVE_TIMEOUT_TICKS);
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
      end
      LOWERING: begin
        if (down_lim) begin
          state_nxt = CLOSED;
        end else if (tick_c) begin
          if (timer_last_c) state_nxt = FAULT;
          else              timer_nxt = timer - TW'(1);
        end
      end
      CLOSED: begin
        if (depart_rise_c) begin
          state_nxt = HOLD;
          timer_nxt = TW'(CLEAR_HOLD_TICKS);
        end
      end
      HOLD: begin
        if (approach_lvl) begin
          state_nxt = CLOSED;
        end else if (tick_c) begin
          if (timer_last_c) begin
            state_nxt = RAISING;
            timer_nxt = TW'(MOVE_TIMEOUT_TICKS);
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
      end
      RAISING: begin
        if (approach_rise_c) begin
          state_nxt = LOWERING;
          timer_nxt = TW'(MOVE_TIMEOUT_TICKS);
        end else if (up_lim) begin
          state_nxt = IDLE;
        end else if (tick_c) begin
          if (timer_last_c) state_nxt = FAULT;
          else              timer_nxt = timer - TW'(1);
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
    if (down_lim && up_lim) state_nxt = FAULT;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Prescaler realigns on every state change so each state's tick count is exact.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                              presc <= '0;
    else if (state_nxt != state || tick_c)  presc <= '0;
    else                                    presc <= presc + PW'(1);
  end

  // Lamp phase: forced on when a warning starts, flips on every tick while active.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                                   blink <= 1'b0;
    else if (state_nxt == WARN && state != WARN) blink <= 1'b1;
    else if (tick_c && lamp_active_c)            blink <= ~blink;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      motor_down <= 1'b0;
      motor_up   <= 1'b0;
      LED1       <= 1'b0;
      LED2       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      motor_down <= (state == LOWERING);
      motor_up   <= (state == RAISING);
      LED1       <= (state == FAULT) | (lamp_active_c & blink);
      LED2       <= (state == CLOSED) | (state == HOLD);
      fault      <= (state == FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rail_gate_sequencer.sv
// Bench for rail_gate_sequencer: directed crossing scenarios plus a randomized gate plant,
// all checked every cycle against a time-in-state reference model.
module tb_rail_gate_sequencer;

  localparam int TICK = 10, DEB = 4, WARN_T = 3, MOVE_T = 5, CLEAR_T = 2;
  localparam int M_IDLE = 0, M_WARN = 1, M_LOWERING = 2, M_CLOSED = 3,
                 M_HOLD = 4, M_RAISING = 5, M_FAULT = 6;
  localparam int PMAX = 10;

  logic clk = 1'b0, reset = 1'b1;
  logic approach_in = 1'b0, depart_in = 1'b0, gate_down_lim = 1'b0, gate_up_lim = 1'b1;
  logic motor_down, motor_up, LED1, LED2, fault;
  logic [2:0] state_dbg;

  int total = 0, bad = 0;
  bit running = 1'b0;

  rail_gate_sequencer #(
    .TICK_CYCLES(TICK), .DEB_CYCLES(DEB), .WARN_TICKS(WARN_T),
    .MOVE_TIMEOUT_TICKS(MOVE_T), .CLEAR_HOLD_TICKS(CLEAR_T)
  ) dut (
    .clk_100MHz(clk), .reset(reset),
    .approach_in(approach_in), .depart_in(depart_in),
    .gate_down_lim(gate_down_lim), .gate_up_lim(gate_up_lim),
    .motor_down(motor_down), .motor_up(motor_up),
    .LED1(LED1), .LED2(LED2), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: two-stage input delay, window debounce, age-in-state timing.
  logic [3:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= {gate_up_lim, gate_down_lim, depart_in, approach_in};
    p2 <= p1;
  end

  int st = M_IDLE, age = 0;
  bit lamp = 0, deb_a = 0, deb_d = 0, prev_a = 0, prev_d = 0;
  bit hq_a[$], hq_d[$];
  bit [4:0] want_o = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st = M_IDLE; age = 0; lamp = 0;
      deb_a = 0; deb_d = 0; prev_a = 0; prev_d = 0;
      hq_a.delete(); hq_d.delete();
      want_o = '0;
    end else begin
      bit ra, rd, tick, act, fa, fd;
      int nx, last;
      ra   = deb_a && !prev_a;
      rd   = deb_d && !prev_d;
      tick = (age % TICK) == TICK - 1;
      nx   = st;
      case (st)
        M_IDLE:     if (ra) nx = M_WARN; else if (!p2[3]) nx = M_RAISING;
        M_WARN:     if (age == WARN_T * TICK - 1) nx = M_LOWERING;
        M_LOWERING: if (p2[2]) nx = M_CLOSED; else if (age == MOVE_T * TICK - 1) nx = M_FAULT;
        M_CLOSED:   if (rd) nx = M_HOLD;
        M_HOLD:     if (deb_a) nx = M_CLOSED; else if (age == CLEAR_T * TICK - 1) nx = M_RAISING;
        M_RAISING: begin
          if (ra) nx = M_LOWERING;
          else if (p2[3]) nx = M_IDLE;
          else if (age == MOVE_T * TICK - 1) nx = M_FAULT;
        end
        default: ;
      endcase
      if (p2[2] && p2[3]) nx = M_FAULT;
      act = (st >= M_WARN) && (st <= M_RAISING);
      want_o = {st == M_LOWERING, st == M_RAISING, (st == M_FAULT) || (act && lamp),
                (st == M_CLOSED) || (st == M_HOLD), st == M_FAULT};
      if (nx == M_WARN && st != M_WARN) lamp = 1;
      else if (act && tick) lamp = !lamp;
      age = (nx != st) ? 0 : age + 1;
      prev_a = deb_a; prev_d = deb_d;
      hq_a.push_back(p2[0]); if (hq_a.size() > DEB) void'(hq_a.pop_front());
      hq_d.push_back(p2[1]); if (hq_d.size() > DEB) void'(hq_d.pop_front());
      fa = (hq_a.size() == DEB); foreach (hq_a[i]) if (hq_a[i] == deb_a) fa = 0;
      fd = (hq_d.size() == DEB); foreach (hq_d[i]) if (hq_d[i] == deb_d) fd = 0;
      if (fa) deb_a = !deb_a;
      if (fd) deb_d = !deb_d;
      last = nx;
      st = last;
    end
  end

  always @(negedge clk) begin
    if (running) begin
      logic [7:0] got, want;
      got  = {motor_down, motor_up, LED1, LED2, fault, state_dbg};
      want = {want_o, 3'(st)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b want=%b (md mu l1 l2 f st)", $time, got, want);
      end
      total++;
      if (motor_down && motor_up) begin
        bad++;
        $display("FAIL motor_exclusive t=%0t got both=1 want at most one", $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_state(input int s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(state_dbg) != s && n < budget);
    total++;
    if (int'(state_dbg) != s) begin
      bad++;
      $display("FAIL wait_state_%0d: got state %0d after %0d cycles want %0d", s, state_dbg, n, s);
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  initial begin
    int n, pos, hold_a, hold_d;
    bit jam;
    running = 1'b1;
    step(4);
    check("reset_outs", {motor_down, motor_up, LED1, LED2, fault, state_dbg}, 0);
    reset = 1'b0;
    step(3);
    check("idle_after_reset", state_dbg, M_IDLE);

    // Nominal pass
    approach_in = 1;
    wait_state(M_WARN, 20, n);     check("warn_latency", n, 7);
    step(1);                       check("lamp_on_warn", LED1, 1);
    wait_state(M_LOWERING, 40, n); check("warn_length", n, 29);
    step(1);                       check("motor_down_lowering", {motor_down, motor_up}, 2);
    gate_up_lim = 0; gate_down_lim = 1;
    wait_state(M_CLOSED, 10, n);   check("closed_latency", n, 3);
    step(1);                       check("led2_closed", LED2, 1);
    approach_in = 0; step(10);
    depart_in = 1; step(5);
    wait_state(M_HOLD, 10, n);     check("hold_latency", n, 2);
    depart_in = 0;
    wait_state(M_RAISING, 30, n);  check("hold_length", n, 20);
    gate_down_lim = 0; step(3); gate_up_lim = 1;
    wait_state(M_IDLE, 10, n);     check("idle_latency", n, 3);
    step(1);                       check("idle_outs", {motor_down, motor_up, LED1, LED2, fault}, 0);

    // Following train keeps the gate closed
    approach_in = 1;
    wait_state(M_LOWERING, 60, n);
    gate_up_lim = 0; gate_down_lim = 1;
    wait_state(M_CLOSED, 10, n);
    depart_in = 1;
    wait_state(M_HOLD, 15, n);
    depart_in = 0;
    step(1);  check("follow_back_closed", state_dbg, M_CLOSED);
              check("follow_led2", LED2, 1);
    step(40); check("follow_no_raise", state_dbg, M_CLOSED);

    // Both limits in CLOSED
    gate_up_lim = 1;
    wait_state(M_FAULT, 6, n);     check("both_lim_latency", n, 3);
    step(1);                       check("both_lim_outs", {motor_down, motor_up, LED1, LED2, fault}, 5);

    // Lowering timeout
    gate_up_lim = 1; gate_down_lim = 0; approach_in = 0; depart_in = 0;
    do_reset();
    approach_in = 1;
    wait_state(M_LOWERING, 60, n);
    approach_in = 0;
    wait_state(M_FAULT, 70, n);    check("lower_timeout", n, 50);
    step(1);                       check("fault_outs", {motor_down, motor_up, LED1, LED2, fault}, 5);
    for (int i = 0; i < 30; i++) begin
      approach_in = 1'($urandom_range(0, 1));
      depart_in   = 1'($urandom_range(0, 1));
      step(1);
    end
    check("fault_sticky", state_dbg, M_FAULT);

    // Re-approach while raising
    approach_in = 0; depart_in = 0; gate_up_lim = 0; gate_down_lim = 1;
    do_reset();
    wait_state(M_RAISING, 5, n);   check("recover_raise", n, 1);
    approach_in = 1;
    wait_state(M_LOWERING, 12, n); check("reapproach_latency", n, 7);
    step(1);                       check("reapproach_motors", {motor_down, motor_up}, 2);

    // Glitch rejection and async reset mid-lowering
    approach_in = 0; gate_down_lim = 0; gate_up_lim = 1;
    do_reset();
    step(2);
    approach_in = 1; step(3); approach_in = 0;
    step(20);                      check("glitch_idle", state_dbg, M_IDLE);
    approach_in = 1;
    wait_state(M_LOWERING, 60, n);
    approach_in = 0;
    step(3);                       check("pre_reset_motor", motor_down, 1);
    @(posedge clk); #2 reset = 1'b1;
    #1 check("async_reset_motor", motor_down, 0);
    check("async_reset_state", state_dbg, M_IDLE);
    gate_up_lim = 0;
    step(3); reset = 1'b0;
    wait_state(M_RAISING, 5, n);   check("reset_gate_down_raise", n, 1);

    // Randomized traffic against a simple gate plant
    pos = PMAX / 2; hold_a = 0; hold_d = 0; jam = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (cyc % 600 == 599) begin
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
      end
      if (hold_a == 0) begin
        approach_in = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 60);
      end else hold_a--;
      if (hold_d == 0) begin
        depart_in = 1'($urandom_range(0, 1));
        hold_d = $urandom_range(1, 30);
      end else hold_d--;
      if (!jam) begin
        if (motor_down && pos < PMAX && $urandom_range(0, 1) == 1) pos++;
        if (motor_up && pos > 0 && $urandom_range(0, 1) == 1) pos--;
      end
      if ($urandom_range(0, 299) == 0) jam = !jam;
      gate_down_lim = (pos == PMAX);
      gate_up_lim   = (pos == 0);
      if ($urandom_range(0, 999) == 0) begin
        gate_down_lim = 1; gate_up_lim = 1;
      end
    end

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
